// File: rtl/adder_pipe.sv
// Pipelined adder/subtractor/accumulator. The carry chain is cut into STAGES segments,
// and the last stage register is the output register. There is a valid/ready handshake on both sides.
module adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             carry_out,
    output logic             overflow
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic             en;
    logic             accept;
    logic             acc_wr;
    logic             acc_hazard;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;

    // Stage registers: operands travel whole; result bits fill in one segment per stage.
    logic             v_q     [STAGES];
    logic             accop_q [STAGES];
    logic             carry_q [STAGES];
    logic [WIDTH-1:0] opa_q   [STAGES];
    logic [WIDTH-1:0] opb_q   [STAGES];
    logic [WIDTH-1:0] res_q   [STAGES];

    // Per-stage sources: stage 0 is fed by the input port and later stages by their predecessor.
    logic             src_v   [STAGES];
    logic             src_acc [STAGES];
    logic             src_c   [STAGES];
    logic [WIDTH-1:0] src_a   [STAGES];
    logic [WIDTH-1:0] src_b   [STAGES];
    logic [WIDTH-1:0] src_res [STAGES];
    logic [WIDTH-1:0] res_nx  [STAGES];
    logic [SEG:0]     seg_sum [STAGES];

    assign en       = !v_q[LAST] || out_ready;
    assign in_ready = rst_n && en && !(acc_hazard && mode[1]);
    assign accept   = in_valid && in_ready;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        in_b   = b;
        in_cin = 1'b0;
        case (mode)
            2'b01: begin
                in_b   = ~b;
                in_cin = 1'b1;
            end
            2'b10:   in_b = acc;
            2'b11:   in_b = '0;
            default: ;
        endcase
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        if (k == 0) begin : g_first
            assign src_v[k]   = accept;
            assign src_acc[k] = mode[1];
            assign src_c[k]   = in_cin;
            assign src_a[k]   = a;
            assign src_b[k]   = in_b;
            assign src_res[k] = '0;
        end else begin : g_next
            assign src_v[k]   = v_q[k-1];
            assign src_acc[k] = accop_q[k-1];
            assign src_c[k]   = carry_q[k-1];
            assign src_a[k]   = opa_q[k-1];
            assign src_b[k]   = opb_q[k-1];
            assign src_res[k] = res_q[k-1];
        end
        assign seg_sum[k] = {1'b0, src_a[k][k*SEG +: SEG]} + {1'b0, src_b[k][k*SEG +: SEG]}
                          + {{SEG{1'b0}}, src_c[k]};
        assign res_nx[k]  = src_res[k] | (WIDTH'(seg_sum[k][SEG-1:0]) << (k*SEG));
    end

    // NOTE: state is updated with non-blocking assignments only, so every stage sees its
    // predecessor's pre-edge value. Pipeline data is reset as well as the valid bits,
    // because c and the flags must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]     <= 1'b0;
                accop_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                opa_q[k]   <= '0;
                opb_q[k]   <= '0;
                res_q[k]   <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]     <= src_v[k];
                accop_q[k] <= src_acc[k];
                carry_q[k] <= seg_sum[k][SEG];
                opa_q[k]   <= src_a[k];
                opb_q[k]   <= src_b[k];
                res_q[k]   <= res_nx[k];
            end
        end
    end

    // The accumulator is written on the edge where its beat enters the output register.
    assign acc_wr = en && src_v[LAST] && src_acc[LAST];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            acc_hazard <= 1'b0;
        end else begin
            if (acc_wr) acc <= res_nx[LAST];
            if (acc_wr)
                acc_hazard <= 1'b0;
            else if (accept && mode[1])
                acc_hazard <= 1'b1;
        end
    end

    assign out_valid = v_q[LAST];
    assign c         = res_q[LAST];
    assign carry_out = carry_q[LAST];
    assign overflow  = (opa_q[LAST][WIDTH-1] == opb_q[LAST][WIDTH-1])
                    && (res_q[LAST][WIDTH-1] != opa_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_adder_pipe.sv
// Directed and random bench for adder_pipe. A queue-based reference model is checked
// against the outputs every cycle, and literal expectations pin the directed cases.
module tb_adder_pipe;

    localparam int WIDTH  = 32;
    parameter  int STAGES = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic             carry_out;
    logic             overflow;

    adder_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .carry_out(carry_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] c;
        logic        cy;
        logic        ov;
    } res_t;

    typedef struct {
        res_t r;
        logic acc_op;
        int   acc_cyc;
        int   stalls;
        bit   shown;
    } exp_t;

    typedef struct {
        logic [1:0]  md;
        logic [31:0] a;
        logic [31:0] b;
    } beat_t;

    exp_t  exp_q[$];
    res_t  got_q[$];
    beat_t stim[$];
    int    acc_cycles[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    logic [31:0] acc_m = '0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end
    endtask

    // Reference arithmetic, written from the mode table with plain integer operations.
    function automatic res_t model(input logic [1:0] md, input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] accv);
        res_t        r;
        logic [32:0] w;
        case (md)
            2'b00, 2'b10: begin
                if (md == 2'b10) y = accv;
                w    = {1'b0, x} + {1'b0, y};
                r.c  = w[31:0];
                r.cy = w[32];
                r.ov = (x[31] == y[31]) && (r.c[31] != x[31]);
            end
            2'b01: begin
                r.c  = x - y;
                r.cy = (x >= y);
                r.ov = (x[31] != y[31]) && (r.c[31] != x[31]);
            end
            default: begin
                r.c  = x;
                r.cy = 1'b0;
                r.ov = 1'b0;
            end
        endcase
        return r;
    endfunction

    // Compare process: outputs, latency and in_ready are checked every cycle.
    bit   en_m;
    bit   inflight;
    exp_t e;
    res_t rr;
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_out_valid", 64'(out_valid), 64'(0));
            check("reset_in_ready", 64'(in_ready), 64'(0));
            exp_q.delete();
            acc_m = '0;
        end else begin
            en_m = !out_valid || out_ready;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_out_valid: got c=%0h with no beat outstanding", c);
                end else begin
                    e = exp_q[0];
                    if (!e.shown) begin
                        check("latency", 64'(cyc - e.acc_cyc), 64'(STAGES + e.stalls));
                        e.shown  = 1'b1;
                        exp_q[0] = e;
                    end
                    check("c", 64'(c), 64'(e.r.c));
                    check("carry_out", 64'(carry_out), 64'(e.r.cy));
                    check("overflow", 64'(overflow), 64'(e.r.ov));
                end
            end
            inflight = 1'b0;
            for (int i = 0; i < exp_q.size(); i++)
                if (!exp_q[i].shown && exp_q[i].acc_op) inflight = 1'b1;
            check("in_ready", 64'(in_ready), 64'(en_m && !(inflight && mode[1])));
            if (!en_m) begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (!exp_q[i].shown) begin
                        e = exp_q[i];
                        e.stalls++;
                        exp_q[i] = e;
                    end
                end
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                rr.c  = c;
                rr.cy = carry_out;
                rr.ov = overflow;
                got_q.push_back(rr);
                void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                e.r       = model(mode, a, b, acc_m);
                e.acc_op  = mode[1];
                e.acc_cyc = cyc;
                e.stalls  = 0;
                e.shown   = 1'b0;
                exp_q.push_back(e);
                if (mode[1]) begin
                    acc_m = e.r.c;
                    acc_cycles.push_back(cyc);
                end
            end
            cyc++;
        end
    end

    task automatic add(input logic [1:0] md, input logic [31:0] x, input logic [31:0] y);
        beat_t s;
        s.md = md;
        s.a  = x;
        s.b  = y;
        stim.push_back(s);
    endtask

    // Offer every queued beat, stall out_ready in cycles lo..hi (or randomly), then drain.
    task automatic stream(input int lo, input int hi, input bit rnd);
        int idx = 0;
        int n   = 0;
        got_q.delete();
        acc_cycles.delete();
        while ((idx < stim.size() || exp_q.size() != 0) && n < 4000) begin
            @(posedge clk);
            #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            else     out_ready = !(n >= lo && n <= hi);
            if (idx < stim.size()) begin
                in_valid = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
                mode     = stim[idx].md;
                a        = stim[idx].a;
                b        = stim[idx].b;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            #1;
            if (in_valid && in_ready) idx++;
            n++;
        end
        if (n >= 4000) begin
            total++;
            bad++;
            $display("FAIL stream_timeout: accepted=%0d of %0d, outstanding=%0d", idx, stim.size(), exp_q.size());
        end
        in_valid = 1'b0;
        stim.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        mode      = 2'b00;
        out_ready = 1'b1;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_c", 64'(c), 64'(0));
        check("rst_carry", 64'(carry_out), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Full-width carry ripple through every segment.
        add(2'b00, 32'hFFFF_FFFF, 32'h1);
        stream(-1, -1, 1'b0);
        check("t1_count", 64'(got_q.size()), 64'(1));
        if (got_q.size() == 1) begin
            check("t1_c", 64'(got_q[0].c), 64'h0);
            check("t1_carry", 64'(got_q[0].cy), 64'(1));
            check("t1_ovf", 64'(got_q[0].ov), 64'(0));
        end

        // Borrowing subtract, then signed overflow on add.
        add(2'b01, 32'd5, 32'd7);
        add(2'b00, 32'h7FFF_FFFF, 32'h1);
        stream(-1, -1, 1'b0);
        check("t2_count", 64'(got_q.size()), 64'(2));
        if (got_q.size() == 2) begin
            check("t2_sub_c", 64'(got_q[0].c), 64'hFFFF_FFFE);
            check("t2_sub_carry", 64'(got_q[0].cy), 64'(0));
            check("t2_sub_ovf", 64'(got_q[0].ov), 64'(0));
            check("t2_add_c", 64'(got_q[1].c), 64'h8000_0000);
            check("t2_add_ovf", 64'(got_q[1].ov), 64'(1));
            check("t2_add_carry", 64'(got_q[1].cy), 64'(0));
        end

        // Back-to-back adds with a four-cycle downstream stall.
        for (int i = 0; i < 8; i++) add(2'b00, 32'(i), 32'(i + 1));
        stream(5, 8, 1'b0);
        check("t3_count", 64'(got_q.size()), 64'(8));
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            check("t3_c", 64'(got_q[i].c), 64'(2 * i + 1));

        // Load then accumulate three times; b is garbage and must be ignored.
        add(2'b11, 32'd10, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) add(2'b10, 32'd5, 32'hDEAD_BEEF);
        stream(-1, -1, 1'b0);
        check("t4_count", 64'(got_q.size()), 64'(4));
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check("t4_c", 64'(got_q[i].c), 64'(10 + 5 * i));
        check("t4_acc_accepts", 64'(acc_cycles.size()), 64'(4));
        for (int i = 1; i < acc_cycles.size(); i++)
            check("t4_acc_spacing", 64'(acc_cycles[i] - acc_cycles[i-1]), 64'(STAGES));

        // Reset with three beats in flight, the oldest already at the output.
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            mode     = 2'b00;
            a        = 32'(j + 1);
            b        = 32'h100;
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (STAGES - 3) @(posedge clk);
        #1;
        check("t5_pre_valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("t5_out_valid", 64'(out_valid), 64'(0));
        check("t5_c", 64'(c), 64'(0));
        check("t5_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        check("t5_next_valid", 64'(out_valid), 64'(0));
        rst_n = 1'b1;
        add(2'b10, 32'd7, 32'd0);
        stream(-1, -1, 1'b0);
        check("t5_count", 64'(got_q.size()), 64'(1));
        if (got_q.size() == 1) check("t5_acc_cleared", 64'(got_q[0].c), 64'd7);

        // Random mix with random valid and ready.
        for (int i = 0; i < 400; i++)
            add(2'($urandom_range(0, 3)), $urandom, $urandom);
        stream(-1, -1, 1'b1);
        check("t6_count", 64'(got_q.size()), 64'(400));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
